bcd_up_counter: RTL

BCD_UP_COUNTER -- requirements
Module: bcd_up_counter

---
 rtl/bcd_counter_pkg.sv | 16 +
 rtl/decade_up_digit.sv | 29 ++
 rtl/bcd_up_counter.sv | 58 +++++
 3 files changed

// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the cascaded BCD up-counter.
package bcd_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Map an illegal nibble (A..F) to zero so a digit never holds a non-BCD value.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_ZERO : d;
  endfunction

endpackage

// File: rtl/decade_up_digit.sv
// One decimal digit of the counter: counts 0..9 when CarryIn is high,
// loads a (sanitized) digit on Load, and passes a combinational carry on.
module decade_up_digit
  import bcd_counter_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       CarryIn,
  input  logic       Load,
  input  bcd_digit_t LoadDigit,
  output bcd_digit_t Digit,
  output logic       CarryOut
);

  // Load beats counting; a counting digit at 9 rolls over to 0.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Digit <= BCD_ZERO;
    end else if (Load) begin
      Digit <= bcd_sanitize(LoadDigit);
    end else if (CarryIn) begin
      Digit <= (Digit == BCD_MAX) ? BCD_ZERO : Digit + 4'd1;
    end
  end

  // Carry is zero-latency so the whole chain updates on a single edge.
  assign CarryOut = CarryIn && (Digit == BCD_MAX);

endmodule

// File: rtl/bcd_up_counter.sv
// Synchronous cascaded BCD up-counter of DIGITS decimal digits.
// Optional synchronous load path enabled by defining BCD_UP_LOAD_EN;
// without it the Load/LoadValue ports do not exist and the count only
// changes by increment or reset.
module bcd_up_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Enable,
`ifdef BCD_UP_LOAD_EN
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] LoadValue,
`endif
  output logic [DIGIT_W*DIGITS-1:0] Count,
  output logic                      CarryOut,
  output logic                      Overflow
);

  logic                      load;
  logic [DIGIT_W*DIGITS-1:0] load_value;
  logic [DIGITS:0]           carry;

`ifdef BCD_UP_LOAD_EN
  assign load       = Load;
  assign load_value = LoadValue;
`else
  assign load       = 1'b0;
  assign load_value = '0;
`endif

  assign carry[0] = Enable;
  assign CarryOut = carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    decade_up_digit u_digit (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .CarryIn   (carry[i]),
      .Load      (load),
      .LoadDigit (load_value[DIGIT_W*i +: DIGIT_W]),
      .Digit     (Count[DIGIT_W*i +: DIGIT_W]),
      .CarryOut  (carry[i+1])
    );
  end

  // Flag the all-9 -> all-0 edge; a load on that edge suppresses the wrap.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Overflow <= 1'b0;
    end else begin
      Overflow <= carry[DIGITS] && !load;
    end
  end

endmodule
